axi4_lite_regfile: RTL and testbench

AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile

---
 rtl/axi4_lite_pkg.sv | 17 +
 rtl/axi4_lite_wstrb_merge.sv | 22 ++
 rtl/axi4_lite_regfile.sv | 236 +++++++++++++++++++++++
 tb/tb_axi4_lite_regfile.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite register file.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_COLLECT = 1'b0,
    WR_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_ADDR = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_wstrb_merge.sv
// Byte-lane merge: each lane takes i_new where its strobe bit is set, else keeps i_old.
module axi4_lite_wstrb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_new,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  output logic [DATA_WIDTH-1:0]   o_merged
);

  localparam int STRB_W = DATA_WIDTH / 8;

  always_comb begin
    o_merged = i_old;
    for (int b = 0; b < STRB_W; b++) begin
      if (i_strb[b]) begin
        o_merged[8*b +: 8] = i_new[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file with independent write and read FSMs, byte strobes,
// read-only register mask and SLVERR for out-of-range or read-only writes.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int                  ADDRESS    = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 32,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDRESS-1:0]      S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDRESS-1:0]      S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY,
  output wr_state_t               o_dbg_wr_state,
  output rd_state_t               o_dbg_rd_state
);

  // Handshakes: a beat transfers on a rising edge where VALID and READY are both 1.
  // VALID outputs come only from registers; READY outputs are forced low in reset.

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // ---------------- write path ----------------
  wr_state_t             r_wr_state;
  wr_state_t             w_wr_state_next;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDRESS-1:0]    r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic                  w_aw_rdy;
  logic                  w_w_rdy;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_commit;
  logic [ADDRESS-1:0]    w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_wr_in_range;
  logic                  w_wr_ok;
  logic [DATA_WIDTH-1:0] w_merged;

  // A channel arriving on the commit edge is used directly rather than via its holding register.
  assign w_wr_addr     = r_aw_held ? r_awaddr : S_AWADDR;
  assign w_wr_data     = r_w_held  ? r_wdata  : S_WDATA;
  assign w_wr_strb     = r_w_held  ? r_wstrb  : S_WSTRB;
  assign w_wr_idx      = w_wr_addr[OFF_W +: IDX_W];
  assign w_wr_in_range = (w_wr_addr >> OFF_W) < ADDRESS'(NUM_REGS);
  assign w_wr_ok       = w_wr_in_range && !RO_MASK[w_wr_idx];

  always_comb begin
    w_wr_state_next = r_wr_state;
    w_aw_rdy        = 1'b0;
    w_w_rdy         = 1'b0;
    w_aw_hs         = 1'b0;
    w_w_hs          = 1'b0;
    w_commit        = 1'b0;
    case (r_wr_state)
      WR_COLLECT: begin
        w_aw_rdy = ARESETN && !r_aw_held;
        w_w_rdy  = ARESETN && !r_w_held;
        w_aw_hs  = S_AWVALID && w_aw_rdy;
        w_w_hs   = S_WVALID && w_w_rdy;
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
          w_commit        = ARESETN;
          w_wr_state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (S_BREADY) begin
          w_wr_state_next = WR_COLLECT;
        end
      end
      default: w_wr_state_next = WR_COLLECT;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_wr_state <= WR_COLLECT;
    end else begin
      r_wr_state <= w_wr_state_next;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (r_wr_state == WR_RESP && S_BREADY) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= S_AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_WDATA;
        r_wstrb  <= S_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bvalid && S_BREADY) begin
      r_bvalid <= 1'b0;
    end
  end

  axi4_lite_wstrb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .i_old    (r_regs[w_wr_idx]),
    .i_new    (w_wr_data),
    .i_strb   (w_wr_strb),
    .o_merged (w_merged)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && w_wr_ok) begin
      r_regs[w_wr_idx] <= w_merged;
    end
  end

  // ---------------- read path ----------------
  rd_state_t             r_rd_state;
  rd_state_t             w_rd_state_next;
  logic                  w_ar_rdy;
  logic                  w_ar_hs;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_rd_in_range;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  assign w_rd_idx      = S_ARADDR[OFF_W +: IDX_W];
  assign w_rd_in_range = (S_ARADDR >> OFF_W) < ADDRESS'(NUM_REGS);

  always_comb begin
    w_rd_state_next = r_rd_state;
    w_ar_rdy        = 1'b0;
    w_ar_hs         = 1'b0;
    case (r_rd_state)
      RD_ADDR: begin
        w_ar_rdy = ARESETN;
        w_ar_hs  = S_ARVALID && w_ar_rdy;
        if (w_ar_hs) begin
          w_rd_state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (S_RREADY) begin
          w_rd_state_next = RD_ADDR;
        end
      end
      default: w_rd_state_next = RD_ADDR;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rd_state <= RD_ADDR;
    end else begin
      r_rd_state <= w_rd_state_next;
    end
  end

  // Storage is updated with <=, so a same-edge write is not yet visible to this capture.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_in_range ? r_regs[w_rd_idx] : '0;
      r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rvalid && S_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{w_wr_addr[OFF_W-1:0], S_ARADDR[OFF_W-1:0]};

  assign S_AWREADY      = w_aw_rdy;
  assign S_WREADY       = w_w_rdy;
  assign S_BVALID       = r_bvalid;
  assign S_BRESP        = r_bresp;
  assign S_ARREADY      = w_ar_rdy;
  assign S_RVALID       = r_rvalid;
  assign S_RDATA        = r_rdata;
  assign S_RRESP        = r_rresp;
  assign o_dbg_wr_state = r_wr_state;
  assign o_dbg_rd_state = r_rd_state;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Bench for axi4_lite_regfile: two instances share stimulus, u0 fully writable, u1 with reg 2 read-only.
module tb_axi4_lite_regfile;
  import axi4_lite_pkg::*;

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] SLV = 2'b10;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;

  logic        awready0, wready0, bvalid0, arready0, rvalid0;
  logic [1:0]  bresp0, rresp0;
  logic [31:0] rdata0;
  wr_state_t   wst0;
  rd_state_t   rst0;
  logic        awready1, wready1, bvalid1, arready1, rvalid1;
  logic [1:0]  bresp1, rresp1;
  logic [31:0] rdata1;
  wr_state_t   wst1;
  rd_state_t   rst1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  axi4_lite_regfile #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(32), .RO_MASK(32'h0)) u0 (
    .ACLK(clk), .ARESETN(arst_n),
    .S_AWADDR(awaddr), .S_AWVALID(awvalid), .S_AWREADY(awready0),
    .S_WDATA(wdata), .S_WSTRB(wstrb), .S_WVALID(wvalid), .S_WREADY(wready0),
    .S_BRESP(bresp0), .S_BVALID(bvalid0), .S_BREADY(bready),
    .S_ARADDR(araddr), .S_ARVALID(arvalid), .S_ARREADY(arready0),
    .S_RDATA(rdata0), .S_RRESP(rresp0), .S_RVALID(rvalid0), .S_RREADY(rready),
    .o_dbg_wr_state(wst0), .o_dbg_rd_state(rst0)
  );

  axi4_lite_regfile #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(32), .RO_MASK(32'h4)) u1 (
    .ACLK(clk), .ARESETN(arst_n),
    .S_AWADDR(awaddr), .S_AWVALID(awvalid), .S_AWREADY(awready1),
    .S_WDATA(wdata), .S_WSTRB(wstrb), .S_WVALID(wvalid), .S_WREADY(wready1),
    .S_BRESP(bresp1), .S_BVALID(bvalid1), .S_BREADY(bready),
    .S_ARADDR(araddr), .S_ARVALID(arvalid), .S_ARREADY(arready1),
    .S_RDATA(rdata1), .S_RRESP(rresp1), .S_RVALID(rvalid1), .S_RREADY(rready),
    .o_dbg_wr_state(wst1), .o_dbg_rd_state(rst1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_total++;
    n_bad++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write: AW and W presented together, then B accepted as soon as it appears.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] r0, output logic [1:0] r1);
    bit aw_d = 0;
    bit w_d  = 0;
    bit hs_aw, hs_w;
    int n = 0;
    r0 = 'x;
    r1 = 'x;
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!(aw_d && w_d) && n < 20) begin
      hs_aw = awvalid && awready0;
      hs_w  = wvalid && wready0;
      step();
      if (hs_aw) begin awvalid = 1'b0; aw_d = 1; end
      if (hs_w)  begin wvalid = 1'b0;  w_d = 1;  end
      n++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_d && w_d)) timeout("wr_addr_data");
    n = 0;
    while (!bvalid0 && n < 20) begin step(); n++; end
    if (!bvalid0) begin
      timeout("wr_bvalid");
    end else begin
      r0 = bresp0;
      r1 = bresp1;
      bready = 1'b1;
      step();
      bready = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d0, output logic [31:0] d1,
                    output logic [1:0] r0, output logic [1:0] r1);
    bit done = 0;
    int n = 0;
    d0 = 'x; d1 = 'x; r0 = 'x; r1 = 'x;
    araddr = a; arvalid = 1'b1;
    while (!done && n < 20) begin
      done = arready0;
      step();
      n++;
    end
    arvalid = 1'b0;
    if (!done) timeout("rd_addr");
    n = 0;
    while (!rvalid0 && n < 20) begin step(); n++; end
    if (!rvalid0) begin
      timeout("rd_rvalid");
    end else begin
      d0 = rdata0; d1 = rdata1; r0 = rresp0; r1 = rresp1;
      rready = 1'b1;
      step();
      rready = 1'b0;
    end
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp0;
    logic [31:0] rdata0;
    logic [1:0]  resp1;
    logic [31:0] rdata1;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  initial begin
    logic [1:0]  r0, r1;
    logic [31:0] d0, d1;

    // Entry state: u0 reg2 = 0xDEADAAEF, u1 reg2 = 0 (read-only), all others 0.
    vec[0]  = '{1'b1, 32'h0000_0004, 32'h0000_0001, 4'hF, OK,  32'h0,         OK,  32'h0};
    vec[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, OK,  32'h0000_0001, OK,  32'h0000_0001};
    vec[2]  = '{1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'hF, SLV, 32'h0,         SLV, 32'h0};
    vec[3]  = '{1'b0, 32'h0000_0080, 32'h0,         4'h0, SLV, 32'h0,         SLV, 32'h0};
    vec[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, OK,  32'hDEAD_AAEF, OK,  32'h0};
    vec[5]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, OK,  32'h0,         SLV, 32'h0};
    vec[6]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, OK,  32'h1234_5678, OK,  32'h0};
    vec[7]  = '{1'b1, 32'h0000_000C, 32'hA5A5_A5A5, 4'h0, OK,  32'h0,         OK,  32'h0};
    vec[8]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, OK,  32'h0,         OK,  32'h0};
    vec[9]  = '{1'b1, 32'h0000_000E, 32'h1122_3344, 4'hC, OK,  32'h0,         OK,  32'h0};
    vec[10] = '{1'b0, 32'h0000_007F, 32'h0,         4'h0, OK,  32'h0,         OK,  32'h0};
    vec[11] = '{1'b1, 32'h0000_007C, 32'hCAFE_BABE, 4'h5, OK,  32'h0,         OK,  32'h0};
    vec[12] = '{1'b0, 32'h0000_007C, 32'h0,         4'h0, OK,  32'h00FE_00BE, OK,  32'h00FE_00BE};
    vec[13] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, OK,  32'h1122_0000, OK,  32'h1122_0000};
    vec[14] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, SLV, 32'h0,         SLV, 32'h0};
    vec[15] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, SLV, 32'h0,         SLV, 32'h0};

    // ---- reset state ----
    repeat (3) step();
    chk("rst_awready", 32'(awready0), 32'h0);
    chk("rst_wready",  32'(wready0),  32'h0);
    chk("rst_arready", 32'(arready0), 32'h0);
    chk("rst_bvalid",  32'(bvalid0),  32'h0);
    chk("rst_rvalid",  32'(rvalid0),  32'h0);
    chk("rst_rdata",   rdata0,        32'h0);
    chk("rst_bresp",   32'(bresp0),   32'h0);
    chk("rst_rresp",   32'(rresp0),   32'h0);
    arst_n = 1'b1;
    step();
    chk("idle_awready", 32'(awready0), 32'h1);
    chk("idle_arready", 32'(arready0), 32'h1);

    // ---- AW at cycle 0, W at cycle 3, BVALID at cycle 4 ----
    awaddr = 32'h8; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("aw_held_awready", 32'(awready0), 32'h0);
    chk("aw_held_wready",  32'(wready0),  32'h1);
    chk("aw_only_bvalid_c1", 32'(bvalid0), 32'h0);
    step();
    chk("aw_only_bvalid_c2", 32'(bvalid0), 32'h0);
    step();
    chk("aw_only_bvalid_c3", 32'(bvalid0), 32'h0);
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("late_w_bvalid_c4", 32'(bvalid0), 32'h1);
    chk("late_w_bresp0",    32'(bresp0),  32'(OK));
    chk("late_w_bresp1_ro", 32'(bresp1),  32'(SLV));
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("late_w_bvalid_drop", 32'(bvalid0), 32'h0);
    rd(32'h8, d0, d1, r0, r1);
    chk("rd08_data0", d0, 32'hDEAD_BEEF);
    chk("rd08_resp0", 32'(r0), 32'(OK));
    chk("rd08_data1_ro", d1, 32'h0);
    chk("rd08_resp1_ro", 32'(r1), 32'(OK));

    // ---- W before AW, byte-1 strobe over 0xDEADBEEF: lane1 BE->AA gives 0xDEADAAEF ----
    wdata = 32'h0000_AA00; wstrb = 4'b0010; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("w_held_wready",  32'(wready0),  32'h0);
    chk("w_held_awready", 32'(awready0), 32'h1);
    chk("w_only_bvalid",  32'(bvalid0),  32'h0);
    step();
    awaddr = 32'h8; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("late_aw_bvalid", 32'(bvalid0), 32'h1);
    chk("late_aw_bresp0", 32'(bresp0),  32'(OK));
    bready = 1'b1;
    step();
    bready = 1'b0;
    rd(32'h8, d0, d1, r0, r1);
    chk("strb_merge_data0", d0, 32'hDEAD_AAEF);

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      if (vec[i].is_wr) begin
        wr(vec[i].addr, vec[i].data, vec[i].strb, r0, r1);
        chk($sformatf("v%0d_bresp0", i), 32'(r0), 32'(vec[i].resp0));
        chk($sformatf("v%0d_bresp1", i), 32'(r1), 32'(vec[i].resp1));
      end else begin
        rd(vec[i].addr, d0, d1, r0, r1);
        chk($sformatf("v%0d_rdata0", i), d0, vec[i].rdata0);
        chk($sformatf("v%0d_rresp0", i), 32'(r0), 32'(vec[i].resp0));
        chk($sformatf("v%0d_rdata1", i), d1, vec[i].rdata1);
        chk($sformatf("v%0d_rresp1", i), 32'(r1), 32'(vec[i].resp1));
      end
    end

    // ---- same-edge read/write of reg 1 (old 0x1), then BREADY low for 5 cycles ----
    awaddr = 32'h4; wdata = 32'h22; wstrb = 4'hF; araddr = 32'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_edge_rvalid", 32'(rvalid0), 32'h1);
    chk("same_edge_rdata0", rdata0, 32'h1);
    chk("same_edge_rdata1", rdata1, 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_bvalid", k),  32'(bvalid0),  32'h1);
      chk($sformatf("hold%0d_bresp", k),   32'(bresp0),   32'(OK));
      chk($sformatf("hold%0d_awready", k), 32'(awready0), 32'h0);
      chk($sformatf("hold%0d_wready", k),  32'(wready0),  32'h0);
      chk($sformatf("hold%0d_rdata", k),   rdata0,        32'h1);
      step();
    end
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    chk("hold_release_bvalid", 32'(bvalid0), 32'h0);
    chk("hold_release_rvalid", 32'(rvalid0), 32'h0);
    rd(32'h4, d0, d1, r0, r1);
    chk("reg1_after_write0", d0, 32'h22);
    chk("reg1_after_write1", d1, 32'h22);

    // ---- reset while in write-response with AW held ----
    awaddr = 32'h10; wdata = 32'h77; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_reset_bvalid", 32'(bvalid0), 32'h1);
    arst_n = 1'b0;
    #1;
    chk("in_reset_arready", 32'(arready0), 32'h0);
    chk("in_reset_awready", 32'(awready0), 32'h0);
    step();
    arst_n = 1'b1;
    chk("post_reset_bvalid", 32'(bvalid0), 32'h0);
    step();
    chk("post_reset_bvalid2", 32'(bvalid0), 32'h0);
    rd(32'h10, d0, d1, r0, r1);
    chk("post_reset_reg4", d0, 32'h0);
    rd(32'h4, d0, d1, r0, r1);
    chk("post_reset_reg1", d0, 32'h0);
    rd(32'h8, d0, d1, r0, r1);
    chk("post_reset_reg2", d0, 32'h0);
    wr(32'h10, 32'hCAFE_F00D, 4'hF, r0, r1);
    chk("post_reset_wr_bresp", 32'(r0), 32'(OK));
    rd(32'h10, d0, d1, r0, r1);
    chk("post_reset_wr_data", d0, 32'hCAFE_F00D);
    chk("post_reset_wr_resp", 32'(r0), 32'(OK));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
    $fatal(1);
  end

endmodule
